// File: rtl/addsub_acc_pipe.sv
// Two-stage pipelined add/sub with running accumulator, valid/ready flow control and carry/ovf flags.
// Optional build macro ADDSUB_SAT_EN: saturate results (and accumulator) on signed overflow.
module addsub_acc_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_q
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             adv_s;
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_carry_q, out_carry_d;
  logic             out_ovf_q, out_ovf_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] x_s, y_s, y_inv_s, sum_s, res_s;
  logic             sub_s, carry_s, ovf_s;

  assign adv_s     = !out_valid_q | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;

  // S2 arithmetic: first operand is the accumulator for ops 10/11
  always_comb begin
    sub_s   = s1_op_q[0];
    x_s     = s1_op_q[1] ? acc_q : s1_a_q;
    y_s     = s1_op_q[1] ? s1_a_q : s1_b_q;
    y_inv_s = y_s ^ {WIDTH{sub_s}};
    {carry_s, sum_s} = {1'b0, x_s} + {1'b0, y_inv_s} + {{WIDTH{1'b0}}, sub_s};
    ovf_s   = (x_s[WIDTH-1] == y_inv_s[WIDTH-1]) & (sum_s[WIDTH-1] != x_s[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (ovf_s) begin
      res_s = x_s[WIDTH-1] ? MIN_NEG : MAX_POS;
    end else begin
      res_s = sum_s;
    end
`else
    res_s = sum_s;
`endif
  end

  // Next-state for both stages and the accumulator; everything holds while stalled
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    if (adv_s) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_op_d = in_op;
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end else begin
        s1_op_d = s1_op_q;
      end
      if (s1_valid_q) begin
        out_data_d  = res_s;
        out_carry_d = carry_s;
        out_ovf_d   = ovf_s;
      end else begin
        out_data_d  = out_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    // Clear beats a completing ACC beat; that beat still outputs its old-acc result
    if (acc_clr) begin
      acc_d = {WIDTH{1'b0}};
    end else if (adv_s && s1_valid_q && s1_op_q[1]) begin
      acc_d = res_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 2'b00;
      s1_a_q      <= {WIDTH{1'b0}};
      s1_b_q      <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Scoreboard bench for addsub_acc_pipe: directed spec cases plus randomized traffic with random backpressure.
module tb_addsub_acc_pipe;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, acc_clr, out_valid, out_ready, out_carry, out_ovf;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b, out_data, acc_q;

  addsub_acc_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .out_ovf(out_ovf), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit c; bit o; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_acc = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Reference: plain integer arithmetic on the operands the op selects
  task automatic model(input logic [1:0] op, input int a, input int b, output exp_t e);
    int x, y, r, sr;
    bit is_sub, is_acc;
    is_sub = op[0];
    is_acc = op[1];
    x = is_acc ? model_acc : a;
    y = is_acc ? a : b;
    if (is_sub) begin
      r = x - y; e.c = (x >= y); sr = sgn(x) - sgn(y);
    end else begin
      r = x + y; e.c = (r >= M); sr = sgn(x) + sgn(y);
    end
    e.o = (sr > M / 2 - 1) || (sr < -(M / 2));
    e.d = (r + M) % M;
`ifdef ADDSUB_SAT_EN
    if (e.o) e.d = (sgn(x) < 0) ? M / 2 : M / 2 - 1;
`endif
    if (is_acc) model_acc = e.d;
  endtask

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", int'(out_data), e.d);
        check("out_carry", int'(out_carry), int'(e.c));
        check("out_ovf", int'(out_ovf), int'(e.o));
      end
    end
  end

  // Random backpressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted
  task automatic send(input logic [1:0] op, input int a, input int b, input bit use_k,
                      input int kd, input bit kc, input bit ko);
    exp_t e;
    int t = 0;
    in_valid = 1'b1; in_op = op; in_a = a[W-1:0]; in_b = b[W-1:0];
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        n_chk++; n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
        break;
      end
    end
    model(op, a, b, e);
    if (use_k) begin
      e.d = kd; e.c = kc; e.o = ko;
      if (op[1]) model_acc = kd;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    model_acc = 0;
    check("acc_after_clr", int'(acc_q), 0);
  endtask

  function automatic int pick();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: return 0;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return $urandom_range(0, M - 1);
    endcase
  endfunction

  initial begin
    logic [W-1:0] hold_d;
    logic         hold_c, hold_o;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_acc", int'(acc_q), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // 1, 2: directed arithmetic
`ifdef ADDSUB_SAT_EN
    send(2'b00, 8'h7F, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
`else
    send(2'b00, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
`endif
    send(2'b01, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(2'b01, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    drain();

    // 3: accumulation chain
    clear_acc();
    send(2'b10, 3, 0, 1'b1, 3, 1'b0, 1'b0);
    send(2'b10, 4, 0, 1'b1, 7, 1'b0, 1'b0);
    send(2'b10, 5, 0, 1'b1, 12, 1'b0, 1'b0);
    drain();
    check("acc_chain", int'(acc_q), 8'h0C);

    // 4: stall with two beats in flight
    out_ready = 1'b0;
    send(2'b00, 8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
    send(2'b01, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    @(negedge clk);
    hold_d = out_data; hold_c = out_carry; hold_o = out_ovf;
    check("stall_first_data", int'(hold_d), 8'h30);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), int'(hold_d));
      check("stall_flags", int'({out_carry, out_ovf}), int'({hold_c, hold_o}));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // 5: op11 completing on the same edge as acc_clr
    clear_acc();
    send(2'b11, 8'h01, 0, 1'b1, 8'hFF, 1'b0, 1'b0);
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    model_acc = 0;
    check("clr_wins_acc", int'(acc_q), 0);
    check("clr_beat_valid", int'(out_valid), 1);
    drain();

    // Randomized traffic with backpressure; clears only when idle
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 49) == 0) begin
        drain();
        check("rand_acc", int'(acc_q), model_acc);
        clear_acc();
      end
      send(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 0, 1'b0, 1'b0);
    end
    rand_rdy = 1'b0; out_ready = 1'b1;
    drain();
    check("rand_acc_end", int'(acc_q), model_acc);

    // 6: reset with beats in S1/S2 and a non-zero accumulator
    send(2'b10, 8'h05, 0, 1'b0, 0, 1'b0, 1'b0);
    drain();
    out_ready = 1'b0;
    send(2'b10, 8'h11, 0, 1'b0, 0, 1'b0, 1'b0);
    send(2'b00, 8'h22, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    model_acc = 0;
    check("rst6_out_valid", int'(out_valid), 0);
    check("rst6_acc", int'(acc_q), 0);
    check("rst6_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst6_no_stale", int'(out_valid), 0);
    check("rst6_acc_hold", int'(acc_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
